nfu2_accum_ctrl: RTL and testbench

- Sequences the pipelined NFU-2 sum/max trees (one internal pipe register, 2-cycle latency) across a multi-tile accumulation for one output-neuron tile.
- Holds the running partial result internally and feeds it back on the tree's partial-sum input.
- Keeps the tree op stable while beats are in flight, and hands the final Tn results to NBout with a valid/ready handshake.
- Sits between the NFU-1 beat source, the NFU-2 tree array and the NBout write port.

---
 rtl/nfu2_accum_ctrl_pkg.sv | 21 ++
 rtl/nfu2_accum_ctrl_if.sv | 47 ++++
 rtl/nfu2_acc_reg.sv | 33 +++
 rtl/nfu2_accum_ctrl.sv | 110 +++++++++++
 tb/tb_nfu2_accum_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nfu2_accum_ctrl_pkg.sv
// nfu2_accum_ctrl_pkg
//   Shared definitions for the NFU-2 accumulation controller: tree op
//   encodings, controller state encoding and default datapath sizes.
package nfu2_accum_ctrl_pkg;

    localparam int N_DEF     = 16;
    localparam int TN_DEF    = 16;
    localparam int N_OPS_DEF = 1;
    localparam int CNT_W_DEF = 8;

    localparam logic OP_SUM = 1'b0;
    localparam logic OP_MAX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/nfu2_accum_ctrl_if.sv
// nfu2_accum_ctrl_if
//   Bundles the command, beat, tree and NBout-write signals of the
//   accumulation controller.
//   Handshakes: a transfer happens on a rising edge where valid & ready are
//   both 1; valid may be raised without waiting for ready, and the offered
//   payload stays stable until the transfer happens.
//   Modports:
//     slave  - the controller (nfu2_accum_ctrl)
//     master - the environment: command source, NFU-1 beat source,
//              NFU-2 tree result and NBout write port
interface nfu2_accum_ctrl_if #(
    parameter int N     = 16,
    parameter int Tn    = 16,
    parameter int N_OPS = 1,
    parameter int CNT_W = 8
);
    logic               i_cmd_valid;
    logic               o_cmd_ready;
    logic [N_OPS-1:0]   i_cmd_op;
    logic [CNT_W-1:0]   i_cmd_ntiles;
    logic               i_cmd_use_nbout;
    logic [N*Tn-1:0]    i_nbout_data;
    logic               i_in_valid;
    logic               o_in_ready;
    logic [N_OPS-1:0]   o_tree_op;
    logic [N*Tn-1:0]    o_tree_nbout;
    logic [N*Tn-1:0]    i_tree_result;
    logic               o_out_valid;
    logic               i_out_ready;
    logic [N*Tn-1:0]    o_out_data;
    logic               o_busy;

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_ntiles, i_cmd_use_nbout,
               i_nbout_data, i_in_valid, i_tree_result, i_out_ready,
        output o_cmd_ready, o_in_ready, o_tree_op, o_tree_nbout,
               o_out_valid, o_out_data, o_busy
    );

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_ntiles, i_cmd_use_nbout,
               i_nbout_data, i_in_valid, i_tree_result, i_out_ready,
        input  o_cmd_ready, o_in_ready, o_tree_op, o_tree_nbout,
               o_out_valid, o_out_data, o_busy
    );

endinterface

// File: rtl/nfu2_acc_reg.sv
// nfu2_acc_reg
//   Wide accumulator register holding the running partial results of all
//   lanes. Seed has priority over capture; otherwise the value holds.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset (clears to 0)
//     seed_en     - load seed_data (command accept)
//     seed_data   - initial partial results
//     cap_en      - load cap_data (tree stage 2 valid)
//     cap_data    - tree result
//     acc         - current accumulator value
module nfu2_acc_reg #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_en,
    input  logic [W-1:0] seed_data,
    input  logic         cap_en,
    input  logic [W-1:0] cap_data,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (seed_en) begin
            acc <= seed_data;
        end else if (cap_en) begin
            acc <= cap_data;
        end
    end

endmodule

// File: rtl/nfu2_accum_ctrl.sv
// nfu2_accum_ctrl
//   Sequences the 2-stage NFU-2 sum/max trees over a multi-beat accumulation
//   for one output-neuron tile. The running partial lives in nfu2_acc_reg and
//   is fed back on o_tree_nbout; the final result goes to NBout over a
//   valid/ready handshake.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     bus        - command / beat / tree / output signals (slave side)
//     dbg_state  - current FSM state for observation
module nfu2_accum_ctrl
    import nfu2_accum_ctrl_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int Tn    = TN_DEF,
    parameter int N_OPS = N_OPS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nfu2_accum_ctrl_if.slave      bus,
    output state_t                dbg_state
);

    state_t             state_q, state_d;
    logic [N_OPS-1:0]   op_r;
    logic [CNT_W-1:0]   cnt;
    logic               v1;
    logic [N*Tn-1:0]    acc;
    logic               cmd_accept;
    logic               beat;

    assign cmd_accept = bus.i_cmd_valid & bus.o_cmd_ready;
    assign beat       = bus.i_in_valid & bus.o_in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = (bus.i_cmd_ntiles == '0) ? ST_OUT : ST_RUN;
                end
            end
            ST_RUN: begin
                // The beat taking cnt from 1 to 0 is the last one.
                if (beat && cnt == CNT_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT: begin
                if (bus.i_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: pure functions of the registered state
    always_comb begin
        bus.o_cmd_ready = (state_q == ST_IDLE);
        bus.o_in_ready  = (state_q == ST_RUN);
        bus.o_out_valid = (state_q == ST_OUT);
        bus.o_busy      = (state_q != ST_IDLE);
    end

    // Op, beat counter and stage-2 valid pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= '0;
            cnt  <= '0;
            v1   <= 1'b0;
        end else begin
            v1 <= beat;
            if (cmd_accept) begin
                op_r <= bus.i_cmd_op;
                cnt  <= bus.i_cmd_ntiles;
            end else if (beat) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Zero seed doubles as the max identity for unsigned data.
    nfu2_acc_reg #(.W(N*Tn)) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_en   (cmd_accept),
        .seed_data (bus.i_cmd_use_nbout ? bus.i_nbout_data : '0),
        .cap_en    (v1),
        .cap_data  (bus.i_tree_result),
        .acc       (acc)
    );

    assign bus.o_tree_op    = op_r;
    assign bus.o_tree_nbout = acc;
    assign bus.o_out_data   = acc;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_nfu2_accum_ctrl.sv
// tb_nfu2_accum_ctrl
//   Directed bench for nfu2_accum_ctrl with a behavioural 2-stage tree model,
//   driver tasks, and a scoreboard queue drained by an output monitor.
module tb_nfu2_accum_ctrl;
    import nfu2_accum_ctrl_pkg::*;

    localparam int N  = 16;
    localparam int TN = 16;
    localparam int W  = N * TN;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    nfu2_accum_ctrl_if #(.N(N), .Tn(TN), .N_OPS(1), .CNT_W(8)) bus_if ();

    nfu2_accum_ctrl #(.N(N), .Tn(TN), .N_OPS(1), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- tree model ----------------
    logic [W-1:0] beat_data;
    logic [W-1:0] tree_pipe;

    always @(posedge clk) tree_pipe <= beat_data;

    always @* begin
        logic [N-1:0] a, b;
        bus_if.i_tree_result = '0;
        for (int l = 0; l < TN; l++) begin
            a = tree_pipe[l*N +: N];
            b = bus_if.o_tree_nbout[l*N +: N];
            if (bus_if.o_tree_op == OP_MAX) begin
                bus_if.i_tree_result[l*N +: N] = (a > b) ? a : b;
            end else begin
                bus_if.i_tree_result[l*N +: N] = a + b;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    function automatic logic [W-1:0] rep(input logic [N-1:0] v);
        logic [W-1:0] r;
        for (int l = 0; l < TN; l++) r[l*N +: N] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus_if.o_out_valid && bus_if.i_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got result %h, expected none", bus_if.o_out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data", bus_if.o_out_data, mon_exp);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic cmd_issue(input logic op, input logic [7:0] n, input logic use_nb,
                             input logic [W-1:0] seed);
        bit ok = 0;
        bus_if.i_cmd_valid     = 1'b1;
        bus_if.i_cmd_op        = op;
        bus_if.i_cmd_ntiles    = n;
        bus_if.i_cmd_use_nbout = use_nb;
        bus_if.i_nbout_data    = seed;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_if.o_cmd_ready) begin ok = 1; break; end
        end
        if (!ok) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus_if.i_cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [N-1:0] v, input logic exp_op);
        bus_if.i_in_valid = 1'b1;
        beat_data = rep(v);
        @(negedge clk);
        check("beat_in_ready", W'(bus_if.o_in_ready), W'(1));
        check("beat_tree_op", W'(bus_if.o_tree_op), W'(exp_op));
        @(posedge clk); #1;
        bus_if.i_in_valid = 1'b0;
        beat_data = '0;
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_if.o_out_valid) begin ok = 1; break; end
        end
        if (!ok) check("out_valid_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_if.i_cmd_valid     = 1'b0;
        bus_if.i_cmd_op        = 1'b0;
        bus_if.i_cmd_ntiles    = '0;
        bus_if.i_cmd_use_nbout = 1'b0;
        bus_if.i_nbout_data    = '0;
        bus_if.i_in_valid      = 1'b0;
        bus_if.i_out_ready     = 1'b1;
        beat_data              = '0;
        rst_n = 1'b0;
        #1;
        check("rst_cmd_ready", W'(bus_if.o_cmd_ready), W'(1));
        check("rst_in_ready", W'(bus_if.o_in_ready), W'(0));
        check("rst_out_valid", W'(bus_if.o_out_valid), W'(0));
        check("rst_tree_nbout", bus_if.o_tree_nbout, '0);
        check("rst_busy", W'(bus_if.o_busy), W'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: sum of 1,2,3 from zero seed; valid 2 cycles after the last beat
        exp_q.push_back(rep(16'd6));
        cmd_issue(OP_SUM, 8'd3, 1'b0, rep(16'hFFFF));
        send_beat(16'd1, OP_SUM);
        send_beat(16'd2, OP_SUM);
        send_beat(16'd3, OP_SUM);
        @(negedge clk);
        check("t1_drain_valid", W'(bus_if.o_out_valid), W'(0));
        check("t1_drain_busy", W'(bus_if.o_busy), W'(1));
        @(negedge clk);
        check("t1_out_valid", W'(bus_if.o_out_valid), W'(1));
        @(posedge clk); #1;

        // 2: max with seeded partial
        exp_q.push_back(rep(16'h0070));
        cmd_issue(OP_MAX, 8'd4, 1'b1, rep(16'h0050));
        send_beat(16'h0010, OP_MAX);
        send_beat(16'h0070, OP_MAX);
        send_beat(16'h0030, OP_MAX);
        send_beat(16'h0060, OP_MAX);
        wait_valid();

        // 3: sum with 3 bubble cycles between beats
        exp_q.push_back(rep(16'd12));
        cmd_issue(OP_SUM, 8'd2, 1'b0, '0);
        send_beat(16'd5, OP_SUM);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k >= 1) check("t3_bubble_acc", bus_if.o_tree_nbout, rep(16'd5));
            @(posedge clk); #1;
        end
        send_beat(16'd7, OP_SUM);
        wait_valid();

        // 4: zero tiles -> seed straight to OUT
        exp_q.push_back(rep(16'h1234));
        cmd_issue(OP_SUM, 8'd0, 1'b1, rep(16'h1234));
        @(negedge clk);
        check("t4_out_valid", W'(bus_if.o_out_valid), W'(1));
        check("t4_in_ready", W'(bus_if.o_in_ready), W'(0));
        @(posedge clk); #1;

        // 5: backpressure with a pending command
        bus_if.i_out_ready = 1'b0;
        exp_q.push_back(rep(16'd9));
        exp_q.push_back(rep(16'h00AB));
        cmd_issue(OP_SUM, 8'd1, 1'b0, '0);
        send_beat(16'd9, OP_SUM);
        wait_valid();
        bus_if.i_cmd_valid     = 1'b1;
        bus_if.i_cmd_op        = OP_MAX;
        bus_if.i_cmd_ntiles    = 8'd0;
        bus_if.i_cmd_use_nbout = 1'b1;
        bus_if.i_nbout_data    = rep(16'h00AB);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_hold_valid", W'(bus_if.o_out_valid), W'(1));
            check("t5_hold_data", bus_if.o_out_data, rep(16'd9));
            check("t5_cmd_blocked", W'(bus_if.o_cmd_ready), W'(0));
            @(posedge clk); #1;
        end
        bus_if.i_out_ready = 1'b1;
        @(negedge clk);             // handshake of the held result
        @(negedge clk);
        check("t5_idle_cmd_ready", W'(bus_if.o_cmd_ready), W'(1));
        @(posedge clk); #1;
        bus_if.i_cmd_valid = 1'b0;
        @(negedge clk);
        check("t5_new_op", W'(bus_if.o_tree_op), W'(OP_MAX));
        @(posedge clk); #1;

        // 6: reset in the middle of a run
        cmd_issue(OP_SUM, 8'd3, 1'b0, '0);
        send_beat(16'd1, OP_SUM);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cmd_ready", W'(bus_if.o_cmd_ready), W'(1));
        check("t6_rst_in_ready", W'(bus_if.o_in_ready), W'(0));
        check("t6_rst_out_valid", W'(bus_if.o_out_valid), W'(0));
        check("t6_rst_tree_op", W'(bus_if.o_tree_op), W'(0));
        check("t6_rst_tree_nbout", bus_if.o_tree_nbout, '0);
        check("t6_rst_busy", W'(bus_if.o_busy), W'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t6_no_valid", W'(bus_if.o_out_valid), W'(0));
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
